// File: rtl/des_decryption_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : des_decryption_pipelined
// Purpose  : Fully pipelined DES decryption. Each cycle it accepts one
//            ciphertext block. One IP stage, sixteen Feistel round stages
//            and one FP/output stage follow, so a block's result is valid
//            18 edges after it is accepted. Round keys are supplied in
//            encryption order and applied K16 first.
// Option   : DES_DEC_CBC_EN adds an iv input and CBC chaining on the output.
// Revision : 1.0 - initial release
// ============================================================================
module des_decryption_pipelined (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:64]   message,
   input  logic          key_load,
   input  logic [1:768]  round_keys,
`ifdef DES_DEC_CBC_EN
   input  logic [1:64]   iv,
`endif
   output logic          busy,
   output logic          key_err,
   output logic          output_valid,
   output logic [1:64]   result
);

   localparam int c_IP [64] = '{58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
                                62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
                                57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
                                61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};
   localparam int c_FP [64] = '{40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
                                38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
                                36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
                                34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};
   localparam int c_E  [48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
                                12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                                24,25,26,27,28,29, 28,29,30,31,32, 1};
   localparam int c_P  [32] = '{16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
                                 2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
   // Each S-box is 64 nibbles, row-major (row*16 + column), first entry in the MSBs.
   localparam logic [255:0] c_SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   function automatic logic [1:64] f_ip(input logic [1:64] x);
      logic [1:64] o;
      for (int i = 0; i < 64; i++) o[i+1] = x[c_IP[i]];
      return o;
   endfunction

   function automatic logic [1:64] f_fp(input logic [1:64] x);
      logic [1:64] o;
      for (int i = 0; i < 64; i++) o[i+1] = x[c_FP[i]];
      return o;
   endfunction

   // Round function: expand, mix key, substitute, permute.
   function automatic logic [1:32] f_feistel(input logic [1:32] r, input logic [1:48] k);
      logic [1:48] x;
      logic [1:32] s;
      logic [1:32] o;
      logic [1:6]  b;
      logic [5:0]  idx;
      for (int i = 0; i < 48; i++) x[i+1] = r[c_E[i]];
      x = x ^ k;
      for (int n = 0; n < 8; n++) begin
         b   = x[6*n+1 +: 6];
         idx = {b[1], b[6], b[2:5]};
         s[4*n+1 +: 4] = c_SBOX[n][(63 - int'(idx))*4 +: 4];
      end
      for (int i = 0; i < 32; i++) o[i+1] = s[c_P[i]];
      return o;
   endfunction

   logic [0:17]  r_vld;
   logic [1:32]  r_l [0:16];
   logic [1:32]  r_r [0:16];
   logic [1:768] r_key;
   logic [1:64]  w_ip;
   logic [1:64]  w_fp;
   logic [1:64]  w_chain;
   logic         w_load_ok;

   assign busy         = |r_vld;
   assign output_valid = r_vld[17];
   assign w_load_ok    = key_load & ~busy;
   assign w_ip         = f_ip(message);
   assign w_fp         = f_fp({r_r[16], r_l[16]});

`ifdef DES_DEC_CBC_EN
   logic [1:64] r_prev_ct;
   logic [1:64] r_cv [0:16];

   assign w_chain = r_cv[16];

   // Chain register: reseeded from iv on an accepted load, then follows each accepted ciphertext.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_ct <= '0;
      end else if (start) begin
         r_prev_ct <= message;
      end else if (w_load_ok) begin
         r_prev_ct <= iv;
      end
   end

   // Carry each block's predecessor ciphertext alongside it; a block entering with a load uses the new iv.
   always_ff @(posedge clk) begin
      r_cv[0] <= w_load_ok ? iv : r_prev_ct;
      for (int i = 1; i <= 16; i++) r_cv[i] <= r_cv[i-1];
   end
`else
   assign w_chain = '0;
`endif

   // Datapath: IP into stage 0, then sixteen rounds with keys taken K16 down to K1.
   always_ff @(posedge clk) begin
      r_l[0] <= w_ip[1:32];
      r_r[0] <= w_ip[33:64];
      for (int i = 1; i <= 16; i++) begin
         r_l[i] <= r_r[i-1];
         r_r[i] <= r_l[i-1] ^ f_feistel(r_r[i-1], r_key[48*(16-i)+1 +: 48]);
      end
   end

   // Control: valid shift chain, guarded key load, load-error pulse and held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld   <= '0;
         r_key   <= '0;
         key_err <= 1'b0;
         result  <= '0;
      end else begin
         r_vld   <= {start, r_vld[0:16]};
         key_err <= key_load & busy;
         if (w_load_ok) r_key <= round_keys;
         if (r_vld[16]) result <= w_fp ^ w_chain;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_des_decryption_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_decryption_pipelined
// Purpose  : Scoreboard bench for des_decryption_pipelined. Ciphertexts come
//            from a forward DES encryption model; the expected plaintext and
//            the accepting edge are queued and compared when output_valid rises.
// Option   : DES_DEC_CBC_EN enables the iv port and chained expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_decryption_pipelined;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:64]   message;
   logic          key_load;
   logic [1:768]  round_keys;
   logic          busy;
   logic          key_err;
   logic          output_valid;
   logic [1:64]   result;
`ifdef DES_DEC_CBC_EN
   logic [1:64]   iv;
`endif

   des_decryption_pipelined dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .message      (message),
      .key_load     (key_load),
      .round_keys   (round_keys),
`ifdef DES_DEC_CBC_EN
      .iv           (iv),
`endif
      .busy         (busy),
      .key_err      (key_err),
      .output_valid (output_valid),
      .result       (result)
   );

   always #5 clk = ~clk;

   localparam int c_ip_t [64] = '{58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
                                  62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
                                  57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
                                  61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};
   localparam int c_e_t  [48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
                                  12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                                  24,25,26,27,28,29, 28,29,30,31,32, 1};
   localparam int c_p_t  [32] = '{16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
                                   2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
   localparam logic [255:0] c_sbox [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   // Subkeys of DES key 133457799BBCDFF1, K1 first.
   localparam logic [1:768] c_keys_a = {
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

   typedef struct {
      logic [1:64] exp;
      int          stamp;
   } sb_item_t;

   sb_item_t    sb [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic        mon_en = 1'b0;
   logic [1:64] tb_prev = '0;
   logic [1:64] tb_iv   = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [1:32] tb_f(input logic [1:32] r, input logic [1:48] k);
      logic [1:48] x;
      logic [1:32] s;
      logic [1:32] o;
      int          idx;
      for (int i = 0; i < 48; i++) x[i+1] = r[c_e_t[i]];
      x ^= k;
      for (int n = 0; n < 8; n++) begin
         idx = 32*int'(x[6*n+1]) + 16*int'(x[6*n+6]) + 8*int'(x[6*n+2])
             + 4*int'(x[6*n+3]) + 2*int'(x[6*n+4]) + int'(x[6*n+5]);
         for (int b = 0; b < 4; b++) s[4*n+1+b] = c_sbox[n][255 - 4*idx - b];
      end
      for (int i = 0; i < 32; i++) o[i+1] = s[c_p_t[i]];
      return o;
   endfunction

   // Forward DES; the final permutation is applied as the inverse of IP.
   function automatic logic [1:64] tb_enc(input logic [1:64] p, input logic [1:768] k);
      logic [1:64] t;
      logic [1:64] o;
      logic [1:32] l;
      logic [1:32] r;
      logic [1:32] tmp;
      for (int i = 0; i < 64; i++) t[i+1] = p[c_ip_t[i]];
      l = t[1:32];
      r = t[33:64];
      for (int rd = 1; rd <= 16; rd++) begin
         tmp = r;
         r   = l ^ tb_f(r, k[48*(rd-1)+1 +: 48]);
         l   = tmp;
      end
      t = {r, l};
      for (int i = 0; i < 64; i++) o[c_ip_t[i]] = t[i+1];
      return o;
   endfunction

   function automatic logic [1:64] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Output monitor: every valid result must match the oldest queued expectation, 18 edges after its start.
   always @(negedge clk) begin
      if (mon_en && output_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", {63'd0, output_valid}, 64'd0);
         end else begin
            sb_item_t e;
            e = sb.pop_front();
            check("result", result, e.exp);
            check("latency", 64'(cyc - e.stamp), 64'd17);
         end
      end
   end

   // d is the raw block decryption of c; chaining is folded in here.
   task automatic send(input logic [1:64] c, input logic [1:64] d);
      sb_item_t it;
      start   = 1'b1;
      message = c;
      it.exp   = d ^ tb_prev;
      it.stamp = cyc + 1;
      sb.push_back(it);
`ifdef DES_DEC_CBC_EN
      tb_prev = c;
`endif
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      start    = 1'b0;
      key_load = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [1:768] k);
      key_load   = 1'b1;
      round_keys = k;
`ifdef DES_DEC_CBC_EN
      iv      = tb_iv;
      tb_prev = tb_iv;
`endif
      @(negedge clk);
      key_load = 1'b0;
   endtask

   task automatic send_load(input logic [1:768] k, input logic [1:64] c, input logic [1:64] d);
      key_load   = 1'b1;
      round_keys = k;
`ifdef DES_DEC_CBC_EN
      iv      = tb_iv;
      tb_prev = tb_iv;
`endif
      send(c, d);
      key_load = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      idle(2);
   endtask

   initial begin
      logic [1:64]  p;
      logic [1:64]  p2;
      logic [1:64]  c1;
      logic [1:64]  c2;
      logic [1:768] kb;

      rst        = 1'b1;
      start      = 1'b0;
      key_load   = 1'b0;
      message    = '0;
      round_keys = '0;
`ifdef DES_DEC_CBC_EN
      iv = '0;
`endif
      repeat (2) @(negedge clk);
      check("rst_output_valid", {63'd0, output_valid}, 64'd0);
      check("rst_busy",         {63'd0, busy},         64'd0);
      check("rst_key_err",      {63'd0, key_err},      64'd0);
      check("rst_result",       result,                64'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Zero key known answer, busy held for all 18 cycles then released.
      load('0);
      send(64'h8CA64DE9C1B123A7, 64'h0);
      start = 1'b0;
      for (int k = 0; k < 18; k++) begin
         check("busy_inflight", {63'd0, busy}, 64'd1);
         @(negedge clk);
      end
      check("busy_after", {63'd0, busy}, 64'd0);
      drain();

      // Classic worked-example key.
      load(c_keys_a);
      send(64'h85E813540F0AB405, 64'h0123456789ABCDEF);
      idle(1);
      drain();

      // 100 back-to-back zero-key blocks.
      load('0);
      for (int i = 0; i < 100; i++) begin
         p = rnd64();
         send(tb_enc(p, '0), p);
      end
      idle(1);
      drain();

      // Arbitrary independent subkeys.
      for (int i = 0; i < 24; i++) kb[32*i+1 +: 32] = $urandom;
      load(kb);
      for (int i = 0; i < 16; i++) begin
         p = rnd64();
         send(tb_enc(p, kb), p);
      end
      idle(1);
      drain();

      // Load while busy is refused with a one-cycle error pulse.
      load(c_keys_a);
      p = rnd64();
      send(tb_enc(p, c_keys_a), p);
      start      = 1'b0;
      key_load   = 1'b1;
      round_keys = kb;
      @(negedge clk);
      check("key_err_pulse", {63'd0, key_err}, 64'd1);
      key_load = 1'b0;
      p = rnd64();
      send(tb_enc(p, c_keys_a), p);
      check("key_err_clear", {63'd0, key_err}, 64'd0);
      idle(1);
      drain();

      // Load together with start while idle: the block uses the new keys.
      p = rnd64();
      send_load(kb, tb_enc(p, kb), p);
      check("key_err_idle", {63'd0, key_err}, 64'd0);
      idle(1);
      drain();

      // Reset with ten blocks in flight drops them and clears the keys.
      load(c_keys_a);
      for (int i = 0; i < 10; i++) begin
         p = rnd64();
         send(tb_enc(p, c_keys_a), p);
      end
      start = 1'b0;
      rst   = 1'b1;
      sb.delete();
      @(negedge clk);
      check("flush_busy",         {63'd0, busy},         64'd0);
      check("flush_result",       result,                64'd0);
      check("flush_output_valid", {63'd0, output_valid}, 64'd0);
      rst     = 1'b0;
      tb_prev = '0;
      idle(25);
      send(64'h8CA64DE9C1B123A7, 64'h0);
      idle(1);
      drain();

`ifdef DES_DEC_CBC_EN
      // Two CBC-chained blocks, back to back and then with a three-cycle gap.
      tb_iv = 64'h0123456789ABCDEF;
      p  = rnd64();
      p2 = rnd64();
      c1 = tb_enc(p ^ tb_iv, c_keys_a);
      c2 = tb_enc(p2 ^ c1, c_keys_a);
      load(c_keys_a);
      send(c1, p ^ tb_iv);
      send(c2, p2 ^ c1);
      idle(1);
      drain();
      load(c_keys_a);
      send(c1, p ^ tb_iv);
      idle(3);
      send(c2, p2 ^ c1);
      idle(1);
      drain();
`else
      c1 = '0;
      c2 = '0;
      p2 = c1 ^ c2;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/des_decryption_pipelined.md
Name: des_decryption_pipelined

Overview:
- Fully pipelined DES decryption core; the inverse of des_encryption_pipelined.
- Accepts one 64-bit ciphertext block per cycle and emits the plaintext a fixed number of cycles later.
- Takes the same 768-bit encryption-order round-key bus (K1 in bits [1:48] … K16 in bits [721:768]) and applies the keys in reverse order internally (K16 first).
- Keys are latched by an explicit load, only while the pipeline is empty, so in-flight blocks never see a key change.

Parameters:
LATENCY, 18, cycles from start sampled to output_valid (1 IP stage + 16 round stages + 1 FP/output stage); fixed, not overridable in practice

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  message valid this cycle; block accepted on every rising edge with start=1
message  input  [1:64]  ciphertext block
key_load  input  1  latch round_keys into the internal key register (accepted only when busy=0)
round_keys  input  [1:768]  encryption-order round keys, K1..K16, 48 bits each
busy  output  1  any pipeline stage holds a valid block
key_err  output  1  one-cycle pulse: key_load asserted while busy=1 (load ignored)
output_valid  output  1  result valid this cycle
result  output  [1:64]  plaintext block

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset, sampled at a rising edge with rst=1: clears all stage valid bits, output_valid=0, result=0, busy=0, key_err=0, key register=0. Data registers other than result are don't-care.
- rst has priority over start and key_load in the same cycle. Reset mid-operation drops all in-flight blocks; no output_valid follows.
- Stage 0: IP(message) is registered with valid=start.
- Stage r (r=1..16): standard Feistel round using key register slice K(17-r). L/R and valid advance every cycle. No stall, no backpressure.
- Stage 17: FP(R16‖L16), i.e. swap then final permutation, is registered into result.
- output_valid equals the stage-17 valid bit. result holds its last value when output_valid=0.
- Throughput: 1 block/cycle. Back-to-back starts give back-to-back outputs in the same order.
- Latency: a block sampled at edge N appears with output_valid=1 in the cycle after edge N+17 (18 edges total).
- busy = OR of valid bits across stages 0..17, registered view.
- Key load rules:
  - key_load=1 with busy=0: round_keys captured at that edge. A start in the same cycle uses the NEW keys.
  - key_load=1 with busy=1: keys unchanged, key_err=1 for exactly the next cycle.
- Widths: the E-expansion output is 48 bits and is XORed with a 48-bit subkey. S-box outputs are 4 bits each, concatenated to 32 bits, then P-permuted.
- Bit numbering is MSB=bit 1, as in the FIPS 46-3 tables.

Optional Feature:
DES_DEC_CBC_EN
- Defined:
  - Adds input iv [1:64]; iv is latched together with round_keys on an accepted key_load.
  - An internal chain register prev_ct is initialised to iv on key_load. Each accepted block carries the current prev_ct down the pipeline, and prev_ct is then updated to message.
  - result = FP output XOR the carried value, giving CBC decryption P_i = D(C_i) ^ C_{i-1}.
  - Reset clears iv and prev_ct to 0. Gaps in start do not disturb the chain.
- Undefined: no iv port, no chain logic, pure ECB; port list exactly as above.

Test Plan:
- Reset then key_load with round_keys=0; start with message=8CA64DE9C1B123A7 -> output_valid=1 exactly 18 cycles later with result=0000000000000000; busy=1 throughout, then 0.
- key_load with keys of DES key 133457799BBCDFF1 (K1=1B02EFFC7072 … K16=CB3D8B0E17F5); message=85E813540F0AB405 -> result=0123456789ABCDEF after 18 cycles.
- 100 consecutive starts of zero-key ciphertexts produced by the des_encryption_pipelined file vectors -> 100 consecutive output_valid cycles, every result matching the original plaintext, in order, with no bubbles.
- key_load while the pipeline holds a block -> key_err pulses for 1 cycle; the in-flight and later blocks decrypt with the old keys. key_load together with start when idle -> that block uses the new keys.
- Assert rst at cycle 10 with 10 blocks in flight -> output_valid never rises, busy=0 and result=0 next cycle; key register reads back as zero (a subsequent zero-key vector still decrypts correctly).
- DES_DEC_CBC_EN: iv=0123456789ABCDEF, two chained blocks encrypted in CBC by the bench -> both plaintexts recovered. A 3-cycle start gap between the blocks gives the same results.
